// File: rtl/vec_reduce_pkg.sv
// vec_reduce_pkg: shared vector types plus the small IEEE-754 single-precision
// helpers used by the reduction unit.  Floats are carried as 32-bit patterns.
// Denormals are flushed to zero.  NaN is not given special handling.
// Optional feature macro: VEC_REDUCE_MEAN_EN (adds the MEAN op, the SCALE state
// and the multiply helper).
package vec_reduce_pkg;

    typedef enum logic [1:0] {
        VEC_DATA_WRITE_DISABLE,
        VEC_DATA_WRITE_SCALAR,
        VEC_DATA_WRITE_VECTOR
    } VecDataWriteOp_t;

    typedef enum logic [0:0] {
        VEC_DATA_READ_DISABLE,
        VEC_DATA_READ_ENABLE
    } VecDataReadOp_t;

`ifdef VEC_REDUCE_MEAN_EN
    typedef enum logic [1:0] {
        VEC_REDUCE_SUM, VEC_REDUCE_MAX, VEC_REDUCE_MIN, VEC_REDUCE_MEAN
    } VecReduceOp_t;
    typedef enum logic [1:0] {VR_IDLE, VR_ACCUM, VR_SCALE, VR_WRITE} VecReduceState_t;
`else
    typedef enum logic [1:0] {VEC_REDUCE_SUM, VEC_REDUCE_MAX, VEC_REDUCE_MIN} VecReduceOp_t;
    typedef enum logic [1:0] {VR_IDLE, VR_ACCUM, VR_WRITE} VecReduceState_t;
`endif

    // Zero exponent covers both zeros and (flushed) denormals.
    function automatic logic fp_is_zero(logic [31:0] a);
        return a[30:23] == 8'd0;
    endfunction

    // Strict a < b; +0 and -0 compare equal.
    function automatic logic fp_lt(logic [31:0] a, logic [31:0] b);
        logic lt;
        if (fp_is_zero(a) && fp_is_zero(b)) lt = 1'b0;
        else if (fp_is_zero(a))             lt = ~b[31];
        else if (fp_is_zero(b))             lt = a[31];
        else if (a[31] != b[31])            lt = a[31];
        else if (!a[31])                    lt = a[30:0] < b[30:0];
        else                                lt = a[30:0] > b[30:0];
        return lt;
    endfunction

    // a + b, round to nearest even.
    function automatic logic [31:0] fp_add(logic [31:0] a, logic [31:0] b);
        logic [31:0]       x, y;
        logic [26:0]       mx, my, sh;
        logic [27:0]       s;
        logic [24:0]       m;
        logic signed [9:0] e;
        logic [7:0]        d;
        logic              sticky, rnd, found;
        int                lz;
        if (fp_is_zero(a)) return fp_is_zero(b) ? 32'd0 : b;
        if (fp_is_zero(b)) return a;
        // x is the larger magnitude so the result sign is x's sign
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        d  = x[30:23] - y[30:23];
        // hidden bit at 26, three guard/round/sticky bits below the fraction
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d > 8'd26) begin
            sh     = '0;
            sticky = 1'b1;
        end else begin
            sh     = my >> d;
            sticky = (sh << d) != my;
        end
        sh[0] = sh[0] | sticky;
        s = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, sh} : {1'b0, mx} - {1'b0, sh};
        if (s == 28'd0) return 32'd0;
        e = $signed({2'b00, x[30:23]});
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            lz    = 0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (s[i]) found = 1'b1;
                    else      lz++;
                end
            end
            s = s << lz;
            e = e - 10'(lz);
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[26:3]} + {24'd0, rnd};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e <= 0)   return 32'd0;
        if (e >= 255) return {x[31], 8'hFF, 23'd0};
        return {x[31], e[7:0], m[22:0]};
    endfunction

`ifdef VEC_REDUCE_MEAN_EN
    // a * b, round to nearest even.
    function automatic logic [31:0] fp_mul(logic [31:0] a, logic [31:0] b);
        logic [47:0]       p;
        logic [24:0]       m;
        logic signed [9:0] e;
        logic              g, st;
        if (fp_is_zero(a) || fp_is_zero(b)) return 32'd0;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
        end else begin
            m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
        end
        m = m + {24'd0, g & (st | m[0])};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e <= 0)   return 32'd0;
        if (e >= 255) return {a[31] ^ b[31], 8'hFF, 23'd0};
        return {a[31] ^ b[31], e[7:0], m[22:0]};
    endfunction

    // Elaboration-time float pattern of 1.0/w.
    function automatic logic [31:0] fp_recip(int w);
        int          k;
        longint      q;
        logic [24:0] mant;
        k = 0;
        for (int i = 0; i < 20; i++) if ((1 << (i + 1)) <= w) k = i + 1;
        if ((1 << k) == w) return {1'b0, 8'(127 - k), 23'd0};
        // 2^(k+1)/w lies in (1,2); q holds it with one extra bit for rounding
        q    = (longint'(1) << (k + 25)) / longint'(w);
        mant = 25'((q + 1) >> 1);
        return {1'b0, 8'(126 - k), mant[22:0]};
    endfunction
`endif

endpackage

// File: rtl/vec_reduce_alu.sv
// VecReduceAlu: combinational fold step y = f(a, b).
//   a  : running accumulator
//   b  : next element
//   op : SUM/MEAN add, MAX/MIN select; ties keep a
module VecReduceAlu
    import vec_reduce_pkg::*;
(
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  VecReduceOp_t op,
    output logic [31:0]  y
);

    always_comb begin
        y = a;
        case (op)
            VEC_REDUCE_MAX: if (fp_lt(a, b)) y = b;
            VEC_REDUCE_MIN: if (fp_lt(b, a)) y = b;
            default:        y = fp_add(a, b);  // SUM, and the summing phase of MEAN
        endcase
    end

endmodule

// File: rtl/vec_reduce.sv
// vec_reduce: multi-cycle SUM/MAX/MIN reduction of one cache vector, folded one
// element per cycle in lane order, result written back as a scalar cache write.
// Ports:
//   clock, reset (sync, active high)
//   start/op/vec_in/dest_addr/dest_param : request, sampled only in IDLE
//   busy        : any non-IDLE state
//   done        : one-cycle pulse in the write cycle
//   result      : last result, held until the next write cycle
//   write_op/write_addr/write_param/data_out : cache write port
// Optional feature macro: VEC_REDUCE_MEAN_EN adds MEAN (sum, then one SCALE
// cycle multiplying by 1.0/WIDTH).
module vec_reduce
    import vec_reduce_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int ADDR_W = 2,
    localparam int PW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  VecReduceOp_t           op,
    input  logic [WIDTH-1:0][31:0] vec_in,
    input  logic [ADDR_W-1:0]      dest_addr,
    input  logic [PW-1:0]          dest_param,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            result,
    output VecDataWriteOp_t        write_op,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [PW-1:0]          write_param,
    output logic [WIDTH-1:0][31:0] data_out
);

`ifdef VEC_REDUCE_MEAN_EN
    localparam logic [31:0] RECIP = fp_recip(WIDTH);
`endif

    VecReduceState_t        state_q, state_d;
    logic [PW-1:0]          idx_q, idx_d;
    logic [31:0]            acc_q, acc_d;
    logic [31:0]            result_q, result_d;
    logic [WIDTH-1:0][31:0] vbuf_q, vbuf_d;
    VecReduceOp_t           op_q, op_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [PW-1:0]          param_q, param_d;
    logic [31:0]            fold;

    VecReduceAlu u_alu (
        .a  (acc_q),
        .b  (vbuf_q[idx_q]),
        .op (op_q),
        .y  (fold)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= VR_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            vbuf_q   <= '0;
            op_q     <= VEC_REDUCE_SUM;
            addr_q   <= '0;
            param_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            vbuf_q   <= vbuf_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            param_q  <= param_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            VR_IDLE:  if (start) state_d = (WIDTH == 1) ? VR_WRITE : VR_ACCUM;
            VR_ACCUM: if (idx_q == PW'(WIDTH - 1)) begin
`ifdef VEC_REDUCE_MEAN_EN
                state_d = (op_q == VEC_REDUCE_MEAN) ? VR_SCALE : VR_WRITE;
`else
                state_d = VR_WRITE;
`endif
            end
`ifdef VEC_REDUCE_MEAN_EN
            VR_SCALE: state_d = VR_WRITE;
`endif
            VR_WRITE: state_d = VR_IDLE;
            default:  state_d = VR_IDLE;
        endcase
    end

    // Datapath
    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        vbuf_d  = vbuf_q;
        op_d    = op_q;
        addr_d  = addr_q;
        param_d = param_q;
        case (state_q)
            VR_IDLE: if (start) begin
                // snapshot so later cache writes cannot disturb the fold
                vbuf_d  = vec_in;
                acc_d   = vec_in[0];
                idx_d   = PW'(1);
                op_d    = op;
                addr_d  = dest_addr;
                param_d = dest_param;
            end
            VR_ACCUM: begin
                acc_d = fold;
                idx_d = idx_q + PW'(1);
            end
`ifdef VEC_REDUCE_MEAN_EN
            VR_SCALE: acc_d = fp_mul(acc_q, RECIP);
`endif
            default: ;
        endcase
        // result is captured on entry to WRITE and then held
        result_d = result_q;
        if (state_d == VR_WRITE && state_q != VR_WRITE) result_d = acc_d;
    end

    // Outputs decode registered state only
    always_comb begin
        busy        = state_q != VR_IDLE;
        done        = state_q == VR_WRITE;
        write_op    = done ? VEC_DATA_WRITE_SCALAR : VEC_DATA_WRITE_DISABLE;
        data_out    = '0;
        data_out[0] = result_q;
    end

    assign result      = result_q;
    assign write_addr  = addr_q;
    assign write_param = param_q;

endmodule
